// File: rtl/datapath_unit.sv
// Execute/memory datapath: ALU, swept data memory, registered result and flags.
// Define DATAPATH_DMEM_BYPASS_EN for write-first forwarding on store+load.
module datapath_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_BITS-1:0]  count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  alu_c;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   shl_w;
  logic [DATA_WIDTH:0]   shr_w;
  logic [2:0]            sh;
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  w_r_q;
  logic                  nop;
  logic                  run;
  logic                  store;

  always_comb begin
    b     = sel3 ? offset : operand2;
    sh    = b[2:0];
    sum   = {1'b0, operand1} + {1'b0, b};
    diff  = {1'b0, operand1} - {1'b0, b};
    // One spare bit on each side catches the last bit shifted out
    shl_w = {1'b0, operand1} << sh;
    shr_w = {operand1, 1'b0} >> sh;
    alu_y = '0;
    alu_c = 1'b0;
    case (opcode)
      4'h0: begin
        alu_y = sum[DATA_WIDTH-1:0];
        alu_c = sum[DATA_WIDTH];
      end
      4'h1: begin
        alu_y = diff[DATA_WIDTH-1:0];
        alu_c = diff[DATA_WIDTH];
      end
      4'h2: alu_y = operand1 & b;
      4'h3: alu_y = operand1 | b;
      4'h4: alu_y = operand1 ^ b;
      4'h5: alu_y = ~operand1;
      4'h6: begin
        alu_y = shl_w[DATA_WIDTH-1:0];
        alu_c = shl_w[DATA_WIDTH];
      end
      4'h7: begin
        alu_y = shr_w[DATA_WIDTH:1];
        alu_c = shr_w[0];
      end
      4'h8: alu_y = operand1;
      4'h9: alu_y = b;
      4'ha: alu_y = {{(DATA_WIDTH-1){1'b0}}, (operand1 < b)};
      default: ;
    endcase
  end

  assign addr  = alu_y[ADDR_BITS-1:0];
  assign nop   = (opcode == 4'hf);
  assign run   = (state == RUN);
  assign store = run && !nop && w_r && !w_r_q;
  assign busy  = (state == CLEAR);

`ifdef DATAPATH_DMEM_BYPASS_EN
  assign load_data = store ? operand2 : mem[addr];
`else
  assign load_data = mem[addr];
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      CLEAR:   if (&count) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
    if (rst) next_state = CLEAR;
  end

  always_ff @(posedge clk) begin
    state <= next_state;
    if (rst) begin
      count <= '0;
    end else if (state == CLEAR) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[count] <= '0;
      end else if (store) begin
        mem[addr] <= operand2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result2 <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      w_r_q   <= 1'b0;
    end else begin
      w_r_q <= w_r;
      if (run && !nop) begin
        if (sel1) begin
          result2 <= alu_y;
          zero    <= (alu_y == '0);
          carry   <= alu_c;
        end else begin
          result2 <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed plan plus random traffic vs a reference model.
module tb_datapath_unit;

  logic       clk;
  logic       rst;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] offset;
  logic [3:0] opcode;
  logic       sel1;
  logic       sel3;
  logic       w_r;
  logic [7:0] result2;
  logic       zero;
  logic       carry;
  logic       busy;

  int n_cmp;
  int n_err;

  int m_mem [32];
  int m_res;
  int m_z;
  int m_c;
  int m_wrq;
  int m_busy;
  int m_cnt;

  datapath_unit #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .operand1(operand1), .operand2(operand2),
    .offset(offset), .opcode(opcode),
    .sel1(sel1), .sel3(sel3), .w_r(w_r),
    .result2(result2), .zero(zero),
    .carry(carry), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_alu(input int a, input int b, input int op,
                         output int y, output int c);
    int s;
    s = b % 8;
    y = 0;
    c = 0;
    case (op)
      0:  begin y = (a + b) % 256; c = (a + b > 255); end
      1:  begin y = (a - b + 256) % 256; c = (a < b); end
      2:  y = a & b;
      3:  y = a | b;
      4:  y = a ^ b;
      5:  y = 255 - a;
      6:  begin
            y = (a * (1 << s)) % 256;
            c = (s == 0) ? 0 : (a / (1 << (8 - s))) % 2;
          end
      7:  begin
            y = a / (1 << s);
            c = (s == 0) ? 0 : (a / (1 << (s - 1))) % 2;
          end
      8:  y = a;
      9:  y = b;
      10: y = (a < b) ? 1 : 0;
      default: y = 0;
    endcase
  endtask

  task automatic step();
    int y, c, bb, ad;
    bit st;
    @(posedge clk);
    if (rst) begin
      m_busy = 1; m_cnt = 0; m_res = 0;
      m_z = 0; m_c = 0; m_wrq = 0;
    end else if (m_busy != 0) begin
      m_mem[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == 32) m_busy = 0;
      m_wrq = int'(w_r);
    end else begin
      if (opcode != 4'hf) begin
        bb = sel3 ? int'(offset) : int'(operand2);
        ref_alu(int'(operand1), bb, int'(opcode), y, c);
        ad = y % 32;
        st = w_r && (m_wrq == 0);
        if (sel1) begin
          m_res = y; m_z = (y == 0); m_c = c;
        end else begin
          m_res = m_mem[ad];
`ifdef DATAPATH_DMEM_BYPASS_EN
          if (st) m_res = int'(operand2);
`endif
        end
        if (st) m_mem[ad] = int'(operand2);
      end
      m_wrq = int'(w_r);
    end
    #1;
    chk("m_result2", result2, m_res);
    chk("m_zero", zero, m_z);
    chk("m_carry", carry, m_c);
    chk("m_busy", busy, m_busy);
  endtask

  task automatic set_op(input int a, input int b2, input int off,
                        input int op, input bit s1, input bit s3,
                        input bit wr);
    operand1 = 8'(a);
    operand2 = 8'(b2);
    offset   = 8'(off);
    opcode   = 4'(op);
    sel1     = s1;
    sel3     = s3;
    w_r      = wr;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_busy = 1; m_cnt = 0; m_res = 0;
    m_z = 0; m_c = 0; m_wrq = 0;
    foreach (m_mem[i]) m_mem[i] = 0;
    rst = 1'b1;
    set_op(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    step();
    chk("rst_busy", busy, 1);
    chk("rst_result2", result2, 0);
    rst = 1'b0;
    repeat (31) step();
    chk("sweep31_busy", busy, 1);
    chk("sweep31_result2", result2, 0);
    step();
    chk("sweep32_busy", busy, 0);

    set_op(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(); chk("clr_a0", result2, 0);
    operand1 = 8'd7;
    step(); chk("clr_a7", result2, 0);
    operand1 = 8'd31;
    step(); chk("clr_a31", result2, 0);

    set_op(200, 100, 0, 0, 1'b1, 1'b0, 1'b0);
    step();
    chk("add_res", result2, 44);
    chk("add_c", carry, 1);
    chk("add_z", zero, 0);
    set_op(5, 5, 0, 1, 1'b1, 1'b0, 1'b0);
    step();
    chk("sub0_res", result2, 0);
    chk("sub0_z", zero, 1);
    chk("sub0_c", carry, 0);
    set_op(3, 5, 0, 1, 1'b1, 1'b0, 1'b0);
    step();
    chk("subn_res", result2, 254);
    chk("subn_c", carry, 1);

    set_op(3, 8'ha5, 4, 0, 1'b1, 1'b1, 1'b1);
    step();
    chk("st_addr", result2, 7);
    operand2 = 8'h11;
    step();
    set_op(3, 0, 4, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("ld_once", result2, 8'ha5);

    set_op(30, 8'h3c, 5, 0, 1'b1, 1'b1, 1'b1);
    step();
    chk("wrap_addr", result2, 35);
    w_r = 1'b0;
    step();
    set_op(0, 0, 3, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("wrap_ld", result2, 8'h3c);

    set_op(200, 100, 0, 0, 1'b1, 1'b0, 1'b0);
    step();
    set_op(12, 8'h99, 0, 15, 1'b1, 1'b1, 1'b1);
    step();
    chk("nop_res", result2, 44);
    chk("nop_c", carry, 1);
    chk("nop_z", zero, 0);
    set_op(12, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("nop_nowr", result2, 0);

    set_op(9, 8'h77, 0, 0, 1'b0, 1'b1, 1'b1);
    step();
`ifdef DATAPATH_DMEM_BYPASS_EN
    chk("same_addr", result2, 8'h77);
`else
    chk("same_addr", result2, 0);
`endif
    w_r = 1'b0;
    step();
    chk("same_after", result2, 8'h77);

    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (31) step();
    chk("mid_busy31", busy, 1);
    step();
    chk("mid_busy32", busy, 0);
    set_op(3, 0, 4, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk("mid_cleared", result2, 0);

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      operand1 = 8'($urandom);
      operand2 = 8'($urandom);
      offset   = 8'($urandom_range(0, 40));
      opcode   = 4'($urandom_range(0, 15));
      sel1     = 1'($urandom);
      sel3     = 1'($urandom);
      w_r      = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
